// File: rtl/key_pulser.sv
// key_pulser: console key front end. Synchronizes and debounces one raw
// console switch and turns each press into clean one-cycle request pulses,
// with optional auto-repeat while held and hold-off while the machine is busy.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   key_in     in   raw key contact, asynchronous to clk
//   repeat_en  in   REPEAT switch, quasi-static
//   rep_speed  in   repeat interval select, (rep_speed+1)*REP_BASE cycles
//   inhibit    in   machine busy; a due pulse is held off while high
//   pulse      out  one-cycle request pulse
//   key_level  out  debounced key level
//   pending    out  a pulse is due but held off by inhibit

`timescale 1ns/1ps

module key_pulser #(
   parameter int unsigned DEBOUNCE = 100000,
   parameter int unsigned REP_BASE = 2000,
   parameter int unsigned CW       = 17
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_in,
   input  logic       repeat_en,
   input  logic [3:0] rep_speed,
   input  logic       inhibit,
   output logic       pulse,
   output logic       key_level,
   output logic       pending
);

   typedef enum logic [1:0] {
      IDLE,
      FIRE,
      REPWAIT,
      HOLD
   } state_t;

   localparam logic [CW-1:0] DB_LIM = CW'(DEBOUNCE);

   logic          s1_q;
   logic          s2_q;
   logic [CW-1:0] db_cnt_q;
   logic [CW-1:0] db_cnt_d;
   logic          level_q;
   logic          level_d;
   logic [CW-1:0] rep_cnt_q;
   logic [CW-1:0] rep_load;
   state_t        state_q;
   logic          pulse_q;
   logic          pending_q;

   // Reload value for the repeat interval; the count runs down to 0 and the
   // transition into FIRE takes one more edge, giving exact pulse spacing.
   assign rep_load = CW'((32'(rep_speed) + 32'd1) * REP_BASE - 32'd1);

   // Debounce: count consecutive edges where the synchronized input
   // disagrees with the debounced level; any agreement restarts the count.
   always_comb begin
      db_cnt_d = '0;
      level_d  = level_q;
      if (s2_q != level_q) begin
         if (db_cnt_q == DB_LIM) begin
            level_d = ~level_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         db_cnt_q <= '0;
         level_q  <= 1'b0;
      end else begin
         s1_q     <= key_in;
         s2_q     <= s1_q;
         db_cnt_q <= db_cnt_d;
         level_q  <= level_d;
      end
   end

   // Request FSM. A low debounced level overrides everything: it cancels
   // any due pulse and repeat count. The rising edge of the level (seen
   // through level_d) arms FIRE so the pulse lands one edge later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         rep_cnt_q <= '0;
         pulse_q   <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         pulse_q   <= 1'b0;
         pending_q <= 1'b0;
         if (!level_q) begin
            rep_cnt_q <= '0;
            state_q   <= level_d ? FIRE : IDLE;
         end else begin
            unique case (state_q)
               FIRE: begin
                  if (inhibit) begin
                     pending_q <= 1'b1;
                  end else begin
                     pulse_q <= 1'b1;
                     if (repeat_en) begin
                        state_q   <= REPWAIT;
                        rep_cnt_q <= rep_load;
                     end else begin
                        state_q <= HOLD;
                     end
                  end
               end
               REPWAIT: begin
                  if (!repeat_en) begin
                     state_q   <= HOLD;
                     rep_cnt_q <= '0;
                  end else if (rep_cnt_q < CW'(2)) begin
                     state_q   <= FIRE;
                     rep_cnt_q <= '0;
                  end else begin
                     rep_cnt_q <= rep_cnt_q - 1'b1;
                  end
               end
               HOLD: begin
                  state_q <= HOLD;
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign pulse     = pulse_q;
   assign key_level = level_q;
   assign pending   = pending_q;

endmodule
